ieee754divider: RTL and testbench

Iterative IEEE-754 single-precision divider, the inverse companion of the team's floating-point multiplier, sharing its start/done handshake and flag set. It accepts two 32-bit operands on a start pulse and computes a/b with a radix-2 restoring mantissa divider, one quotient bit per cycle. It returns a packed result plus exception flags with a one-cycle done pulse. It sits beside the multiplier in the FP datapath frontend.

---
 rtl/ieee754_pkg.sv | 52 +++++
 rtl/ieee754_mantissa_div.sv | 59 +++++
 rtl/ieee754divider.sv | 219 +++++++++++++++++++++
 tb/tb_ieee754divider.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/ieee754_pkg.sv
// ieee754_pkg
//   Definitions shared by the binary32 multiplier and divider: the common
//   start/done FSM state encoding, exponent constants, canonical special
//   encodings, the exception-flag bundle and an operand classifier.
//   Subnormal operands classify as zero (flush-to-zero on input).
package ieee754_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UNPACK,
        ST_DIVIDE,
        ST_NORMALIZE,
        ST_PACK,
        ST_DONE
    } fp_state_t;

    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_NORMAL,
        CLS_INF,
        CLS_NAN
    } fp_class_t;

    typedef struct packed {
        logic nan;
        logic infinity;
        logic dbz;
        logic overflow;
        logic underflow;
        logic inexact;
    } fp_flags_t;

    // Exponent arithmetic is carried in 10-bit signed form so that both
    // overflow (>= 255) and underflow (<= 0) are visible before packing.
    localparam logic signed [9:0] BIAS    = 10'sd127;
    localparam logic signed [9:0] EXP_MAX = 10'sd255;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam logic [31:0] INF  = 32'h7F80_0000;

    function automatic fp_class_t classify(input logic [31:0] v);
        fp_class_t c;
        if (v[30:23] == 8'h00)
            c = CLS_ZERO;
        else if (v[30:23] == 8'hFF)
            c = (v[22:0] == 23'd0) ? CLS_INF : CLS_NAN;
        else
            c = CLS_NORMAL;
        return c;
    endfunction

endpackage

// File: rtl/ieee754_mantissa_div.sv
// ieee754_mantissa_div
//   Radix-2 restoring divider for 24-bit significands, one quotient bit per
//   clock. Produces a 26-bit quotient floor(ma * 2^25 / mb) plus a sticky bit
//   from the final remainder.
//   Ports:
//     clk, rst_n   clock / async active-low reset
//     load         capture ma/mb, clear quotient, counter := 25
//     step         perform one iteration (compare, subtract, shift)
//     ma, mb       dividend / divisor significands (hidden bit set)
//     q            quotient shift register
//     sticky       final remainder is nonzero
//     last         counter is 0: the step taken now is the final one
module ieee754_mantissa_div (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        step,
    input  logic [23:0] ma,
    input  logic [23:0] mb,
    output logic [25:0] q,
    output logic        sticky,
    output logic        last
);

    logic [24:0] rem;
    logic [23:0] divisor;
    logic [4:0]  cnt;
    logic [25:0] diff;
    logic        ge;

    // Compare-then-shift order keeps the quotient in [2^24, 2^26) because
    // ma/mb lies in (0.5, 2); rem stays below 2^24 before each shift.
    always_comb begin
        diff = {1'b0, rem} - {2'b00, divisor};
        ge   = ~diff[25];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem     <= '0;
            divisor <= '0;
            q       <= '0;
            cnt     <= '0;
        end else if (load) begin
            rem     <= {1'b0, ma};
            divisor <= mb;
            q       <= '0;
            cnt     <= 5'd25;
        end else if (step) begin
            q   <= {q[24:0], ge};
            rem <= ge ? {diff[23:0], 1'b0} : {rem[23:0], 1'b0};
            cnt <= (cnt == 5'd0) ? 5'd0 : cnt - 5'd1;
        end
    end

    assign sticky = (rem != 25'd0);
    assign last   = (cnt == 5'd0);

endmodule

// File: rtl/ieee754divider.sv
// ieee754divider
//   Iterative IEEE-754 binary32 divider (a / b) with start/done handshake.
//   Build option: define IEEE754_DIV_ROUND_EN for round-to-nearest-even;
//   otherwise the quotient is truncated toward zero (same latency).
//   Ports:
//     clk, rst_n        clock / async active-low reset
//     a_i, b_i          dividend / divisor, sampled when start is accepted
//     start_i           request, accepted only while busy_o = 0
//     busy_o            state is not IDLE
//     done_o            one-cycle pulse, result_o and flags valid
//     result_o          packed quotient, held until the next completion
//     nan_o, infinity_o, dbz_o, overflow_o, underflow_o, inexact_o
//                       exception flags, cleared on an accepted start
module ieee754divider
    import ieee754_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] result_o,
    output logic        nan_o,
    output logic        infinity_o,
    output logic        dbz_o,
    output logic        overflow_o,
    output logic        underflow_o,
    output logic        inexact_o
);

    fp_state_t state, state_nx;

    logic [31:0]        a_reg, b_reg;
    logic               sign;
    logic signed [9:0]  exp_r;
    logic               special;
    logic [31:0]        spec_res;
    fp_flags_t          spec_flags;
    logic [25:0]        q_norm;
    fp_flags_t          flags;

    // divider interface
    logic        div_load, div_step;
    logic [25:0] div_q;
    logic        div_sticky, div_last;

    // unpack / special-case decode
    fp_class_t   cls_a, cls_b;
    logic        special_c;
    logic [31:0] spec_res_c;
    fp_flags_t   spec_flags_c;
    logic        sign_c;

    // pack path
    logic [23:0]       sig;
    logic              guard, stk, round_up;
    logic [24:0]       sum;
    logic [22:0]       frac_p;
    logic signed [9:0] exp_p;
    logic [31:0]       res_c;
    fp_flags_t         flags_c;

    ieee754_mantissa_div u_mdiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (div_load),
        .step   (div_step),
        .ma     ({1'b1, a_reg[22:0]}),
        .mb     ({1'b1, b_reg[22:0]}),
        .q      (div_q),
        .sticky (div_sticky),
        .last   (div_last)
    );

    always_comb begin
        cls_a        = classify(a_reg);
        cls_b        = classify(b_reg);
        sign_c       = a_reg[31] ^ b_reg[31];
        special_c    = 1'b1;
        spec_res_c   = '0;
        spec_flags_c = '0;
        if (cls_a == CLS_NAN || cls_b == CLS_NAN ||
            (cls_a == CLS_ZERO && cls_b == CLS_ZERO) ||
            (cls_a == CLS_INF && cls_b == CLS_INF)) begin
            spec_res_c          = QNAN;
            spec_flags_c.nan    = 1'b1;
        end else if (cls_b == CLS_ZERO) begin
            spec_res_c            = {sign_c, INF[30:0]};
            spec_flags_c.dbz      = 1'b1;
            spec_flags_c.infinity = 1'b1;
        end else if (cls_a == CLS_INF) begin
            spec_res_c            = {sign_c, INF[30:0]};
            spec_flags_c.infinity = 1'b1;
        end else if (cls_a == CLS_ZERO || cls_b == CLS_INF) begin
            spec_res_c = {sign_c, 31'd0};
        end else begin
            special_c = 1'b0;
        end
    end

    always_comb begin
        sig   = q_norm[25:2];
        guard = q_norm[1];
        stk   = q_norm[0] | div_sticky;
`ifdef IEEE754_DIV_ROUND_EN
        round_up = guard & (stk | sig[0]);
`else
        round_up = 1'b0;
`endif
        sum = {1'b0, sig} + {24'd0, round_up};
        // carry out means sum == 2^24: renormalise by one place
        frac_p = sum[24] ? sum[23:1] : sum[22:0];
        exp_p  = exp_r + (sum[24] ? 10'sd1 : 10'sd0);

        flags_c = '0;
        if (special) begin
            res_c   = spec_res;
            flags_c = spec_flags;
        end else if (exp_p >= EXP_MAX) begin
            res_c            = {sign, INF[30:0]};
            flags_c.overflow = 1'b1;
            flags_c.infinity = 1'b1;
            flags_c.inexact  = 1'b1;
        end else if (exp_p <= 10'sd0) begin
            res_c             = {sign, 31'd0};
            flags_c.underflow = 1'b1;
            flags_c.inexact   = 1'b1;
        end else begin
            res_c           = {sign, exp_p[7:0], frac_p};
            flags_c.inexact = guard | stk;
        end
    end

    always_comb begin
        state_nx = state;
        div_load = 1'b0;
        div_step = 1'b0;
        case (state)
            ST_IDLE:      if (start_i) state_nx = ST_UNPACK;
            ST_UNPACK: begin
                if (special_c) begin
                    state_nx = ST_PACK;
                end else begin
                    state_nx = ST_DIVIDE;
                    div_load = 1'b1;
                end
            end
            ST_DIVIDE: begin
                div_step = 1'b1;
                if (div_last) state_nx = ST_NORMALIZE;
            end
            ST_NORMALIZE: state_nx = ST_PACK;
            ST_PACK:      state_nx = ST_DONE;
            ST_DONE:      state_nx = ST_IDLE;
            default:      state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            sign       <= 1'b0;
            exp_r      <= '0;
            special    <= 1'b0;
            spec_res   <= '0;
            spec_flags <= '0;
            q_norm     <= '0;
            flags      <= '0;
            result_o   <= '0;
            done_o     <= 1'b0;
        end else begin
            state  <= state_nx;
            done_o <= (state == ST_PACK);
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        a_reg <= a_i;
                        b_reg <= b_i;
                        flags <= '0;
                    end
                end
                ST_UNPACK: begin
                    sign       <= sign_c;
                    special    <= special_c;
                    spec_res   <= spec_res_c;
                    spec_flags <= spec_flags_c;
                    exp_r      <= $signed({2'b00, a_reg[30:23]})
                                - $signed({2'b00, b_reg[30:23]}) + BIAS;
                end
                ST_NORMALIZE: begin
                    if (div_q[25]) begin
                        q_norm <= div_q;
                    end else begin
                        q_norm <= {div_q[24:0], 1'b0};
                        exp_r  <= exp_r - 10'sd1;
                    end
                end
                ST_PACK: begin
                    result_o <= res_c;
                    flags    <= flags_c;
                end
                default: ;
            endcase
        end
    end

    assign busy_o      = (state != ST_IDLE);
    assign nan_o       = flags.nan;
    assign infinity_o  = flags.infinity;
    assign dbz_o       = flags.dbz;
    assign overflow_o  = flags.overflow;
    assign underflow_o = flags.underflow;
    assign inexact_o   = flags.inexact;

endmodule

// File: tb/tb_ieee754divider.sv
// tb_ieee754divider
//   Directed self-checking bench for ieee754divider. Expected results are
//   hand-computed; flags are compared as {nan, inf, dbz, ovf, unf, inexact}.
module tb_ieee754divider;

    logic        clk;
    logic        rst_n;
    logic [31:0] a_i, b_i;
    logic        start_i;
    logic        busy_o, done_o;
    logic [31:0] result_o;
    logic        nan_o, infinity_o, dbz_o, overflow_o, underflow_o, inexact_o;

    int errors = 0;
    int checks = 0;

    ieee754divider dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .a_i         (a_i),
        .b_i         (b_i),
        .start_i     (start_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .result_o    (result_o),
        .nan_o       (nan_o),
        .infinity_o  (infinity_o),
        .dbz_o       (dbz_o),
        .overflow_o  (overflow_o),
        .underflow_o (underflow_o),
        .inexact_o   (inexact_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] flags_now();
        return {nan_o, infinity_o, dbz_o, overflow_o, underflow_o, inexact_o};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one division; start_i is either pulsed for one cycle or held
    // through the whole operation (must not cause a second accept).
    task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input int exp_lat, input logic [31:0] exp_res,
                          input logic [5:0] exp_flags, input logic hold_start);
        int edge_n;
        logic got;
        @(negedge clk);
        a_i = a;
        b_i = b;
        start_i = 1'b1;
        @(posedge clk);               // edge 0
        #1;
        if (!hold_start) start_i = 1'b0;
        a_i = 32'hDEAD_BEEF;          // operands must have been captured already
        b_i = 32'h1234_5678;
        check({tag, " busy"}, {31'd0, busy_o}, 32'd1);
        check({tag, " flags_clr"}, {26'd0, flags_now()}, 32'd0);
        edge_n = 0;
        got = 1'b0;
        while (!got && edge_n < 60) begin
            @(posedge clk);
            edge_n++;
            #1;
            if (done_o) got = 1'b1;
        end
        start_i = 1'b0;
        check({tag, " done_edge"}, edge_n, exp_lat);
        check({tag, " result"}, result_o, exp_res);
        check({tag, " flags"}, {26'd0, flags_now()}, {26'd0, exp_flags});
        @(posedge clk);
        #1;
        check({tag, " done_pulse"}, {31'd0, done_o}, 32'd0);
        check({tag, " idle"}, {31'd0, busy_o}, 32'd0);
        check({tag, " held"}, result_o, exp_res);
    endtask

    initial begin
        logic saw_done;
        rst_n   = 1'b0;
        start_i = 1'b0;
        a_i     = '0;
        b_i     = '0;
        #22;
        check("rst busy",   {31'd0, busy_o}, 32'd0);
        check("rst done",   {31'd0, done_o}, 32'd0);
        check("rst result", result_o, 32'd0);
        check("rst flags",  {26'd0, flags_now()}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_div("6/2",    32'h40C0_0000, 32'h4000_0000, 29, 32'h4040_0000, 6'b000000, 1'b0);
        do_div("-6/2h",  32'hC0C0_0000, 32'h4000_0000, 29, 32'hC040_0000, 6'b000000, 1'b1);
`ifdef IEEE754_DIV_ROUND_EN
        do_div("1/3",    32'h3F80_0000, 32'h4040_0000, 29, 32'h3EAA_AAAB, 6'b000001, 1'b0);
`else
        do_div("1/3",    32'h3F80_0000, 32'h4040_0000, 29, 32'h3EAA_AAAA, 6'b000001, 1'b0);
`endif
        do_div("-1/0",   32'hBF80_0000, 32'h0000_0000,  2, 32'hFF80_0000, 6'b011000, 1'b0);
        do_div("0/0",    32'h0000_0000, 32'h0000_0000,  2, 32'h7FC0_0000, 6'b100000, 1'b0);
        do_div("inf/inf",32'h7F80_0000, 32'h7F80_0000,  2, 32'h7FC0_0000, 6'b100000, 1'b0);
        do_div("nan/1",  32'h7FC0_0001, 32'h3F80_0000,  2, 32'h7FC0_0000, 6'b100000, 1'b0);
        do_div("inf/-2", 32'h7F80_0000, 32'hC000_0000,  2, 32'hFF80_0000, 6'b010000, 1'b0);
        do_div("2/inf",  32'h4000_0000, 32'h7F80_0000,  2, 32'h0000_0000, 6'b000000, 1'b0);
        do_div("sub/1",  32'h0000_0001, 32'h3F80_0000,  2, 32'h0000_0000, 6'b000000, 1'b0);
        do_div("ovf",    32'h7F00_0000, 32'h0080_0000, 29, 32'h7F80_0000, 6'b010101, 1'b0);
        do_div("unf",    32'h0080_0000, 32'h7F00_0000, 29, 32'h0000_0000, 6'b000011, 1'b0);

        // reset in the middle of a division
        @(negedge clk);
        a_i = 32'h40C0_0000;
        b_i = 32'h4000_0000;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (done_o) saw_done = 1'b1;
        end
        rst_n = 1'b0;
        #1;
        check("midrst busy",   {31'd0, busy_o}, 32'd0);
        check("midrst done",   {31'd0, done_o}, 32'd0);
        check("midrst result", result_o, 32'd0);
        check("midrst flags",  {26'd0, flags_now()}, 32'd0);
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (done_o) saw_done = 1'b1;
            if (i == 2) rst_n = 1'b1;
        end
        check("midrst no_done", {31'd0, saw_done}, 32'd0);
        check("midrst idle",    {31'd0, busy_o}, 32'd0);

        do_div("6/2 post", 32'h40C0_0000, 32'h4000_0000, 29, 32'h4040_0000, 6'b000000, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
